// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_e;

    // DMType encodings used on the memory port
    localparam logic [2:0] DM_WORD = 3'b000;
    localparam logic [2:0] DM_BYTE = 3'b011;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN: ties alternate (round-robin on last grant); otherwise DM wins ties.
module mem_arb_pick
    import arb_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  grant_e last_grant,
    output grant_e grant
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores history
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // A lone request always wins; ties resolved by the configured policy
    always_comb begin
        grant = GNT_IF;
        if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
            grant = (last_grant == GNT_DM) ? GNT_IF : GNT_DM;
`else
            grant = GNT_DM;
`endif
        end else if (dm_req) begin
            grant = GNT_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between instruction fetch and data access.
// Optional MEM_ARB_RR_EN: round-robin tie breaking instead of DM priority.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_type,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_type,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        pipe_stall,
    output logic        err
);

    // Counter value seen during the last tolerated busy cycle
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e     state_q;
    logic [7:0] busy_cnt_q;
    grant_e     grant;
    grant_e     last_grant;
    logic       busy_tmo;

    assign pipe_stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);
    assign busy_tmo   = (busy_cnt_q == TMO_LAST);

    mem_arb_pick u_pick (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .last_grant(last_grant),
        .grant     (grant)
    );

`ifdef MEM_ARB_RR_EN
    // Remember every winner so the next tie goes to the other requester
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_IF;
        end else if (state_q == IDLE && (if_req || dm_req)) begin
            last_grant <= grant;
        end
    end
`else
    assign last_grant = GNT_IF;
`endif

    // Arbitration FSM; memory-port and response outputs are all registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_cnt_q <= '0;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_ack     <= 1'b0;
            dm_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_type   <= '0;
            err        <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (if_req || dm_req) begin
                        mem_req    <= 1'b1;
                        busy_cnt_q <= '0;
                        if (grant == GNT_DM) begin
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_type  <= dm_type;
                            state_q   <= BUSY_DM;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_type  <= DM_WORD;
                            state_q   <= BUSY_IF;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // mem_ack takes precedence over a timeout in the same cycle
                    if (mem_ack || busy_tmo) begin
                        mem_req <= 1'b0;
                        state_q <= RESP;
                        if (!mem_ack) begin
                            err <= 1'b1;
                        end
                        if (state_q == BUSY_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int unsigned TMO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_type;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_type;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        pipe_stall;
    logic        err;

    int checks;
    int errors;

    // Reference model state
    grant_e      model_last;
    logic        model_err;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;

    mem_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_type   (dm_type),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_type  (mem_type),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pipe_stall(pipe_stall),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_stall(input logic ia, input logic da);
        return (if_req && !ia) || (dm_req && !da);
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_type = '0; mem_rdata = '0;
        tick;
        tick;
        reset = 1'b0;
        model_last = GNT_IF;
        model_err = 1'b0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
    endtask

    // Serves one grant starting in an IDLE cycle; mem_ack arrives on busy cycle k
    // (k > TMO means memory never answers).
    task automatic serve_one(input int k, input logic [31:0] data, input bit drop_early);
        grant_e      win;
        logic [31:0] e_addr;
        logic        e_we;
        logic [2:0]  e_type;
        bit          tmo;
        #1;
        if (if_req && dm_req) win = (RR_EN && model_last == GNT_DM) ? GNT_IF : GNT_DM;
        else if (dm_req) win = GNT_DM;
        else win = GNT_IF;
        if (win == GNT_DM) begin
            e_addr = dm_addr; e_we = dm_we; e_type = dm_type;
        end else begin
            e_addr = if_addr; e_we = 1'b0; e_type = DM_WORD;
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL idle_mem_req got %0b want 0", mem_req);
        end
        checks++;
        if (pipe_stall !== exp_stall(1'b0, 1'b0)) begin
            errors++; $display("FAIL c0_stall got %0b want %0b", pipe_stall, exp_stall(1'b0, 1'b0));
        end
        tick;
        model_last = win;
        if (drop_early) begin
            if (win == GNT_IF) if_req = 1'b0;
            else dm_req = 1'b0;
            #1;
        end
        for (int b = 1; b <= int'(TMO); b++) begin
            mem_ack = (b == k);
            mem_rdata = (b == k) ? data : $urandom;
            checks++;
            if (mem_req !== 1'b1) begin
                errors++; $display("FAIL busy_mem_req cyc %0d got %0b want 1", b, mem_req);
            end
            checks++;
            if (mem_addr !== e_addr || mem_we !== e_we || mem_type !== e_type) begin
                errors++;
                $display("FAIL busy_mem_fields cyc %0d got %h/%0b/%0d want %h/%0b/%0d",
                         b, mem_addr, mem_we, mem_type, e_addr, e_we, e_type);
            end
            if (win == GNT_DM) begin
                checks++;
                if (mem_wdata !== dm_wdata) begin
                    errors++; $display("FAIL busy_wdata got %h want %h", mem_wdata, dm_wdata);
                end
            end
            checks++;
            if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin
                errors++; $display("FAIL busy_ack got %0b%0b want 00", if_ack, dm_ack);
            end
            checks++;
            if (pipe_stall !== exp_stall(1'b0, 1'b0)) begin
                errors++; $display("FAIL busy_stall got %0b want %0b", pipe_stall, exp_stall(1'b0, 1'b0));
            end
            tick;
            if (b == k) break;
        end
        mem_ack = 1'b0;
        tmo = (k > int'(TMO));
        if (tmo) model_err = 1'b1;
        if (win == GNT_IF) exp_if_rdata = tmo ? 32'h0 : data;
        else exp_dm_rdata = tmo ? 32'h0 : data;
        checks++;
        if (if_ack !== (win == GNT_IF) || dm_ack !== (win == GNT_DM)) begin
            errors++; $display("FAIL resp_ack got if=%0b dm=%0b want winner %s", if_ack, dm_ack, win.name());
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL resp_mem_req got %0b want 0", mem_req);
        end
        checks++;
        if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
            errors++; $display("FAIL resp_rdata got %h/%h want %h/%h", if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
        end
        checks++;
        if (err !== model_err) begin
            errors++; $display("FAIL resp_err got %0b want %0b", err, model_err);
        end
        checks++;
        if (pipe_stall !== exp_stall(win == GNT_IF, win == GNT_DM)) begin
            errors++; $display("FAIL resp_stall got %0b want %0b", pipe_stall, exp_stall(win == GNT_IF, win == GNT_DM));
        end
        if (win == GNT_IF) if_req = 1'b0;
        else dm_req = 1'b0;
        tick;
        checks++;
        if (if_ack !== 1'b0 || dm_ack !== 1'b0) begin
            errors++; $display("FAIL ack_one_cycle got %0b%0b want 00", if_ack, dm_ack);
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({if_ack, dm_ack, mem_req, mem_we, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {if_ack, dm_ack, mem_req, mem_we, err});
        end
        checks++;
        if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, dm_rdata);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_type !== 3'h0) begin
            errors++; $display("FAIL reset_mem got %h/%h/%0d want 0/0/0", mem_addr, mem_wdata, mem_type);
        end
        checks++;
        if (pipe_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %0b want 0", pipe_stall);
        end
    endtask

    task automatic test_fetch;
        if_req = 1'b1;
        if_addr = 32'h0000_0010;
        serve_one(1, 32'h0000_0093, 1'b0);
    endtask

    task automatic test_store;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100;
        dm_wdata = 32'hDEAD_BEEF; dm_type = DM_BYTE;
        serve_one(3, 32'h1234_5678, 1'b0);
        dm_we = 1'b0;
    endtask

    // Winner re-raises immediately so every round is a fresh tie
    task automatic test_ties;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            if_req = 1'b1; if_addr = $urandom;
            dm_req = 1'b1; dm_addr = $urandom; dm_we = 1'($urandom); dm_wdata = $urandom;
            dm_type = 3'($urandom_range(0, 4));
            serve_one(1 + int'($urandom % 2), $urandom, 1'b0);
        end
        while (if_req || dm_req) serve_one(1, $urandom, 1'b0);
    endtask

    task automatic test_timeout;
        if_req = 1'b1; if_addr = 32'h40;
        serve_one(int'(TMO) + 1, $urandom, 1'b0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_type = DM_WORD;
        serve_one(2, 32'hCAFE_0001, 1'b0);
        do_reset;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_cleared got %0b want 0", err);
        end
    endtask

    task automatic test_ack_at_limit;
        if_req = 1'b1; if_addr = 32'h44;
        serve_one(int'(TMO), 32'hABCD_0042, 1'b0);
    endtask

    task automatic test_ack_idle;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick;
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (if_ack !== 1'b0 || dm_ack !== 1'b0 || mem_req !== 1'b0) begin
                errors++; $display("FAIL idle_ack got %0b%0b%0b want 000", if_ack, dm_ack, mem_req);
            end
            checks++;
            if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
                errors++; $display("FAIL idle_rdata got %h/%h want %h/%h", if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h77; dm_type = DM_WORD;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0;
        model_last = GNT_IF; model_err = 1'b0; exp_if_rdata = '0; exp_dm_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_req !== 1'b0 || dm_ack !== 1'b0) begin
                errors++; $display("FAIL rst_mid cyc %0d got req=%0b ack=%0b want 0 0", i, mem_req, dm_ack);
            end
            tick;
        end
        if_req = 1'b1; if_addr = 32'h300;
        serve_one(2, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            if_req = 1'($urandom); dm_req = 1'($urandom);
            if (!if_req && !dm_req) dm_req = 1'b1;
            if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
            dm_we = 1'($urandom); dm_type = 3'($urandom_range(0, 4));
            while (if_req || dm_req) begin
                serve_one(1 + int'($urandom % (TMO + 1)), $urandom, ($urandom % 4) == 0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        test_reset;
        test_fetch;
        test_store;
        test_ties;
        test_timeout;
        test_ack_at_limit;
        test_ack_idle;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning memory-busy cycles tolerated before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch address (PC), stable while if_req.
REQ-006 SHALL have port dm_req  input  1  data-memory request, held until dm_ack.
REQ-007 SHALL have ports dm_we  input  1, dm_addr  input  32, dm_wdata  input  32, dm_type  input  3: write enable, address, store data, DMType, stable while dm_req.
REQ-008 SHALL have ports if_ack  output  1, if_rdata  output  32: one-cycle completion pulse plus registered instruction.
REQ-009 SHALL have ports dm_ack  output  1, dm_rdata  output  32: one-cycle completion pulse plus registered load data.
REQ-010 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32, mem_type  output  3: shared memory port, all registered.
REQ-011 SHALL have ports mem_rdata  input  32, mem_ack  input  1: memory read data and completion, valid together.
REQ-012 SHALL have ports pipe_stall  output  1, err  output  1: pipeline freeze request, sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-014 IDLE: if any request, latch winner's address/data/we/type onto mem_* and go to BUSY_IF or BUSY_DM; else stay IDLE.
REQ-015 Fetch grants SHALL force mem_we=0 and mem_type=word.
REQ-016 BUSY_x: mem_req=1, mem_* held stable; on mem_ack, capture mem_rdata into x_rdata and go to RESP.
REQ-017 RESP: assert the granted requester's x_ack for exactly one cycle, mem_req=0, ignore all requests, then go to IDLE.
REQ-018 Minimum latency SHALL be req cycle 0 -> mem_req cycle 1 -> (mem_ack cycle 1) -> x_ack cycle 2.
REQ-019 Busy counter SHALL clear on entry to BUSY_x and increment each BUSY cycle without mem_ack; at TIMEOUT_CYC: set err, load x_rdata=0, go to RESP (ack still pulsed).
REQ-020 mem_ack in the same cycle the counter reaches TIMEOUT_CYC SHALL win: normal completion, err unchanged.
REQ-021 mem_ack outside BUSY_x SHALL be ignored.
REQ-022 Tie (both req in IDLE) SHALL follow the configured policy (REQ-028); a lone request always wins.
REQ-023 pipe_stall SHALL be combinational: (if_req & ~if_ack) | (dm_req & ~dm_ack).
REQ-024 x_rdata SHALL hold its value until the next completion for that requester.
REQ-025 Requester dropping req mid-transaction SHALL NOT abort it; ack still pulses.

Reset
REQ-026 reset SHALL force state IDLE, counter 0, all outputs 0 (acks, rdata, mem_*, err), last-grant = IF.
REQ-027 reset mid-transaction SHALL drop mem_req next edge with no ack issued.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: tie goes to the requester not granted last (round-robin); undefined: DM always wins ties; last-grant register absent.

Structure
REQ-029 Shared package arb_pkg SHALL hold FSM state encodings, grant encoding (GNT_IF/GNT_DM), DMType word constant, default TIMEOUT_CYC.
REQ-030 Tie/priority logic SHALL be a combinational sub-module mem_arb_pick (inputs if_req, dm_req, last_grant; output grant).

Verification
REQ-031 Fetch, if_addr=0x0000_0010, mem_ack one cycle after mem_req, mem_rdata=0x0000_0093 -> mem_req cycle 1, if_ack cycle 2 (rdata 0x93), pipe_stall high cycles 0-1.
REQ-032 Store dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_type=byte, mem_ack after 3 cycles -> mem_we=1, mem_type=byte held 3 cycles, dm_ack one pulse.
REQ-033 Simultaneous if_req/dm_req repeated 4 times: without MEM_ARB_RR_EN -> all DM first; with -> grants DM,IF,DM,IF.
REQ-034 TIMEOUT_CYC=4, no mem_ack -> RESP after 4 busy cycles, if_ack pulse, if_rdata=0, err=1 until reset.
REQ-035 mem_ack on cycle TIMEOUT_CYC exactly -> data returned, err=0.
REQ-036 reset asserted in BUSY_DM -> next cycle mem_req=0, dm_ack never pulses, state IDLE.
